// File: rtl/instr_register_pipe.sv
// Instruction register file fed by a fixed-latency, non-stalling ALU pipeline.
// Each accepted op commits {opcode, operands, result, flags} PIPE_STAGES cycles later.
module instr_register_pipe #(
    parameter int OP_WIDTH    = 32,
    parameter int DEPTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [3:0]            opcode,
    input  logic [OP_WIDTH-1:0]   operand_a,
    input  logic [OP_WIDTH-1:0]   operand_b,
    input  logic [ADDR_W-1:0]     write_pointer,
    input  logic [ADDR_W-1:0]     read_pointer,
    output logic [3:0]            rd_opcode,
    output logic [OP_WIDTH-1:0]   rd_operand_a,
    output logic [OP_WIDTH-1:0]   rd_operand_b,
    output logic [2*OP_WIDTH-1:0] rd_result,
    output logic [2:0]            rd_flags,
    output logic                  rd_pending,
    output logic                  commit_valid,
    output logic [ADDR_W-1:0]     commit_addr
);

    localparam int RW   = 2 * OP_WIDTH;
    localparam int DW   = 4 + 2 * OP_WIDTH + RW + 2;
    localparam int LAST = PIPE_STAGES - 1;

    logic                 accept;
    logic signed [RW-1:0] ext_a;
    logic signed [RW-1:0] ext_b;
    logic signed [RW-1:0] safe_b;
    logic signed [RW-1:0] quotient;
    logic signed [RW-1:0] remainder;
    logic signed [RW-1:0] alu_result;
    logic                 alu_illegal;
    logic                 alu_dbz;

    logic [PIPE_STAGES-1:0] stage_valid;
    logic [ADDR_W-1:0]      stage_addr [PIPE_STAGES];
    logic [DW-1:0]          stage_data [PIPE_STAGES];

    logic [3:0]          last_opcode;
    logic [OP_WIDTH-1:0] last_a;
    logic [OP_WIDTH-1:0] last_b;
    logic [RW-1:0]       last_result;
    logic                last_illegal;
    logic                last_dbz;

    logic [3:0]          mem_opcode [DEPTH];
    logic [OP_WIDTH-1:0] mem_a      [DEPTH];
    logic [OP_WIDTH-1:0] mem_b      [DEPTH];
    logic [RW-1:0]       mem_result [DEPTH];
    logic [2:0]          mem_flags  [DEPTH];

    assign load_ready = !reset && !clear;
    assign accept     = load_valid && load_ready;

    // Operands are widened first so MULT is exact and MIN/-1 division cannot overflow.
    always_comb begin
        ext_a       = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
        ext_b       = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
        safe_b      = ext_b;
        alu_dbz     = (operand_b == '0);
        alu_illegal = 1'b0;
        alu_result  = '0;
        if (alu_dbz) begin
            safe_b = {{(RW-1){1'b0}}, 1'b1};
        end
        quotient  = ext_a / safe_b;
        remainder = ext_a % safe_b;
        case (opcode)
            4'd0: alu_result = '0;
            4'd1: alu_result = ext_a;
            4'd2: alu_result = ext_b;
            4'd3: alu_result = ext_a + ext_b;
            4'd4: alu_result = ext_a - ext_b;
            4'd5: alu_result = ext_a * ext_b;
            4'd6: alu_result = alu_dbz ? '0 : quotient;
            4'd7: alu_result = alu_dbz ? '0 : remainder;
            default: alu_illegal = 1'b1;
        endcase
        if (opcode != 4'd6 && opcode != 4'd7) begin
            alu_dbz = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= accept;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            stage_addr[0] <= write_pointer;
            stage_data[0] <= {opcode, operand_a, operand_b, alu_result, alu_illegal, alu_dbz};
        end
        for (int i = 1; i < PIPE_STAGES; i++) begin
            stage_addr[i] <= stage_addr[i-1];
            stage_data[i] <= stage_data[i-1];
        end
    end

    assign {last_opcode, last_a, last_b, last_result, last_illegal, last_dbz} = stage_data[LAST];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            commit_valid <= 1'b0;
            commit_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_opcode[i] <= '0;
                mem_a[i]      <= '0;
                mem_b[i]      <= '0;
                mem_result[i] <= '0;
                mem_flags[i]  <= '0;
            end
        end else begin
            commit_valid <= stage_valid[LAST];
            if (stage_valid[LAST]) begin
                commit_addr                <= stage_addr[LAST];
                mem_opcode[stage_addr[LAST]] <= last_opcode;
                mem_a[stage_addr[LAST]]      <= last_a;
                mem_b[stage_addr[LAST]]      <= last_b;
                mem_result[stage_addr[LAST]] <= last_result;
                mem_flags[stage_addr[LAST]]  <= {last_illegal, last_dbz, 1'b1};
            end
        end
    end

    // An op stops counting as pending once it has left the last stage, i.e. in its commit cycle.
    always_comb begin
        rd_pending = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            if (stage_valid[i] && stage_addr[i] == read_pointer) begin
                rd_pending = 1'b1;
            end
        end
    end

    assign rd_opcode    = mem_opcode[read_pointer];
    assign rd_operand_a = mem_a[read_pointer];
    assign rd_operand_b = mem_b[read_pointer];
    assign rd_result    = mem_result[read_pointer];
    assign rd_flags     = mem_flags[read_pointer];

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed and randomized bench for instr_register_pipe against a queue-based
// model of in-flight ops and a plain-array model of the register file.
module tb_instr_register_pipe;

    localparam int OP_WIDTH    = 32;
    localparam int DEPTH       = 32;
    localparam int PIPE_STAGES = 2;
    localparam int ADDR_W      = 5;

    logic                  clk;
    logic                  reset;
    logic                  clear;
    logic                  load_valid;
    logic                  load_ready;
    logic [3:0]            opcode;
    logic [OP_WIDTH-1:0]   operand_a;
    logic [OP_WIDTH-1:0]   operand_b;
    logic [ADDR_W-1:0]     write_pointer;
    logic [ADDR_W-1:0]     read_pointer;
    logic [3:0]            rd_opcode;
    logic [OP_WIDTH-1:0]   rd_operand_a;
    logic [OP_WIDTH-1:0]   rd_operand_b;
    logic [2*OP_WIDTH-1:0] rd_result;
    logic [2:0]            rd_flags;
    logic                  rd_pending;
    logic                  commit_valid;
    logic [ADDR_W-1:0]     commit_addr;

    instr_register_pipe #(
        .OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH), .PIPE_STAGES(PIPE_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
        .rd_result(rd_result), .rd_flags(rd_flags), .rd_pending(rd_pending),
        .commit_valid(commit_valid), .commit_addr(commit_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        op;
        int                a;
        int                b;
        int                age;
    } op_t;

    op_t         inflight[$];
    logic [3:0]  m_op    [DEPTH];
    logic [31:0] m_a     [DEPTH];
    logic [31:0] m_b     [DEPTH];
    logic [63:0] m_res   [DEPTH];
    logic [2:0]  m_flags [DEPTH];
    logic        exp_commit;
    logic [ADDR_W-1:0] exp_commit_addr;
    int          errors = 0;
    int          checks = 0;
    int          pulses;

    function automatic void ref_op(input logic [3:0] op, input int a, input int b,
                                   output longint res, output logic ill, output logic dbz);
        res = 0;
        ill = 1'b0;
        dbz = 1'b0;
        case (op)
            4'd0: res = 0;
            4'd1: res = longint'(a);
            4'd2: res = longint'(b);
            4'd3: res = longint'(a) + longint'(b);
            4'd4: res = longint'(a) - longint'(b);
            4'd5: res = longint'(a) * longint'(b);
            4'd6: if (b == 0) dbz = 1'b1; else res = longint'(a) / longint'(b);
            4'd7: if (b == 0) dbz = 1'b1; else res = longint'(a) % longint'(b);
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic model_pending(input logic [ADDR_W-1:0] addr);
        foreach (inflight[i]) if (inflight[i].addr == addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_inputs(input logic r, input logic c, input logic lv, input logic [3:0] op,
                              input int a, input int b, input logic [ADDR_W-1:0] wp,
                              input logic [ADDR_W-1:0] rp);
        reset         = r;
        clear         = c;
        load_valid    = lv;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        write_pointer = wp;
        read_pointer  = rp;
    endtask

    // Advance one clock edge and move the model forward by what that edge should do.
    task automatic tick();
        logic   r, c, lv, ill, dbz;
        longint res;
        op_t    n;
        op_t    done;
        r = reset;
        c = clear;
        lv = load_valid;
        n.addr = write_pointer;
        n.op = opcode;
        n.a = operand_a;
        n.b = operand_b;
        n.age = 0;
        @(posedge clk);
        #1;
        exp_commit = 1'b0;
        if (r || c) begin
            inflight.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_flags[i] = '0;
            end
        end else begin
            foreach (inflight[i]) inflight[i].age++;
            if (inflight.size() > 0 && inflight[0].age == PIPE_STAGES) begin
                done = inflight.pop_front();
                ref_op(done.op, done.a, done.b, res, ill, dbz);
                m_op[done.addr]    = done.op;
                m_a[done.addr]     = done.a;
                m_b[done.addr]     = done.b;
                m_res[done.addr]   = res;
                m_flags[done.addr] = {ill, dbz, 1'b1};
                exp_commit      = 1'b1;
                exp_commit_addr = done.addr;
            end
            if (lv) inflight.push_back(n);
        end
        pulses += int'(commit_valid);
    endtask

    task automatic check_all();
        check("load_ready", load_ready, !(reset || clear));
        check("commit_valid", commit_valid, exp_commit);
        if (exp_commit) check("commit_addr", commit_addr, exp_commit_addr);
        check("rd_pending", rd_pending, model_pending(read_pointer));
        check("rd_opcode", rd_opcode, m_op[read_pointer]);
        check("rd_operand_a", rd_operand_a, m_a[read_pointer]);
        check("rd_operand_b", rd_operand_b, m_b[read_pointer]);
        check("rd_result", rd_result, m_res[read_pointer]);
        check("rd_flags", rd_flags, m_flags[read_pointer]);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input int a, input int b,
                          input logic [ADDR_W-1:0] addr, input logic [63:0] exp_res,
                          input logic [2:0] exp_flags);
        set_inputs(1'b0, 1'b0, 1'b1, op, a, b, addr, addr);
        tick();
        check_all();
        check({tag, "_pending"}, rd_pending, 1'b1);
        load_valid = 1'b0;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            tick();
            check_all();
            check({tag, "_pending_hold"}, rd_pending, 1'b1);
        end
        tick();
        check_all();
        check({tag, "_commit"}, commit_valid, 1'b1);
        check({tag, "_addr"}, commit_addr, addr);
        check({tag, "_result"}, rd_result, exp_res);
        check({tag, "_flags"}, rd_flags, exp_flags);
        check({tag, "_pending_drop"}, rd_pending, 1'b0);
    endtask

    task automatic read_all_invalid(input string tag);
        load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            read_pointer = ADDR_W'(i);
            tick();
            check_all();
            check({tag, "_flags"}, rd_flags, 3'b000);
        end
    endtask

    initial begin
        pulses = 0;
        exp_commit = 1'b0;
        exp_commit_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_flags[i] = '0;
        end

        set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 0, 0, '0, '0);
        tick();
        tick();
        check_all();
        check("reset_commit_addr", commit_addr, '0);
        check("reset_load_ready", load_ready, 1'b0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", load_ready, 1'b1);
        read_all_invalid("reset_read");

        run_op("add", 4'd3, 7, -3, 5'd5, 64'd4, 3'b001);
        run_op("mult", 4'd5, 32'h7FFFFFFF, 2, 5'd6, 64'h00000000FFFFFFFE, 3'b001);
        run_op("div", 4'd6, -7, 2, 5'd7, -64'sd3, 3'b001);
        run_op("mod", 4'd7, -7, 2, 5'd8, -64'sd1, 3'b001);
        run_op("div0", 4'd6, 5, 0, 5'd9, 64'd0, 3'b011);
        run_op("illegal", 4'd9, 5, 6, 5'd10, 64'd0, 3'b101);
        run_op("divmin", 4'd6, 32'h80000000, -1, 5'd11, 64'h0000000080000000, 3'b001);

        pulses = 0;
        set_inputs(1'b0, 1'b0, 1'b1, 4'd1, 11, 0, 5'd3, 5'd3);
        tick();
        check_all();
        operand_a = 22;
        tick();
        check_all();
        load_valid = 1'b0;
        for (int i = 0; i < PIPE_STAGES + 1; i++) begin
            tick();
            check_all();
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_final", rd_result, 64'd22);

        pulses = 0;
        set_inputs(1'b0, 1'b0, 1'b1, 4'd3, 1, 2, 5'd20, 5'd20);
        tick();
        check_all();
        write_pointer = 5'd21;
        tick();
        check_all();
        clear = 1'b1;
        write_pointer = 5'd22;
        tick();
        check_all();
        check("clear_load_ready", load_ready, 1'b0);
        clear = 1'b0;
        load_valid = 1'b0;
        for (int i = 0; i < PIPE_STAGES + 2; i++) begin
            tick();
            check_all();
        end
        check("clear_no_commit", pulses, 0);
        read_all_invalid("clear_read");

        run_op("refill", 4'd2, 0, 99, 5'd4, 64'd99, 3'b001);
        pulses = 0;
        set_inputs(1'b0, 1'b0, 1'b1, 4'd1, 5, 0, 5'd12, 5'd12);
        tick();
        check_all();
        write_pointer = 5'd13;
        tick();
        check_all();
        reset = 1'b1;
        write_pointer = 5'd14;
        tick();
        check_all();
        check("reset_mid_load_ready", load_ready, 1'b0);
        reset = 1'b0;
        load_valid = 1'b0;
        for (int i = 0; i < PIPE_STAGES + 2; i++) begin
            tick();
            check_all();
        end
        check("reset_no_commit", pulses, 0);
        read_all_invalid("reset_mid_read");

        for (int k = 0; k < 600; k++) begin
            logic [3:0] op;
            int a;
            int b;
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = -1;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            set_inputs($urandom_range(0, 80) == 0, $urandom_range(0, 40) == 0,
                       $urandom_range(0, 3) != 0, op, a, b,
                       ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
            tick();
            check_all();
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
